// File: rtl/wide_add_seq_pkg.sv
// Shared types and constants for the sequential wide adder/subtractor.
package wide_add_seq_pkg;

  localparam int W_DEF = 16;
  localparam int K_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // A single-slice build still needs a 1-bit index register.
  function automatic int idxWidth(input int k);
    return (k <= 1) ? 1 : $clog2(k);
  endfunction

endpackage

// File: rtl/wide_add_seq_rca.sv
// 16-bit ripple-carry adder slice shared by the wide_add_seq controller.
module rca_16b (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        cin_i,
  output logic [15:0] sum_o,
  output logic        cout_o
);

  logic carry;

  always_comb begin
    sum_o = '0;
    carry = cin_i;
    for (int i = 0; i < 16; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
      carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
    end
    cout_o = carry;
  end

endmodule

// File: rtl/wide_add_seq.sv
// Multi-cycle W*K-bit add/sub built on one shared 16-bit slice, LSB slice first.
// Optional accumulate input enabled by defining WIDE_ADD_SEQ_ACC_EN.
module wide_add_seq
  import wide_add_seq_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int K = K_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W*K-1:0] in_a,
  input  logic [W*K-1:0] in_b,
  input  logic           in_sub,
`ifdef WIDE_ADD_SEQ_ACC_EN
  input  logic           in_acc,
`endif
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W*K-1:0] out_sum,
  output logic           out_cout,
  output logic           out_ovf
);

  localparam int IW = idxWidth(K);

  state_e         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           carry_q, carry_d;
  logic           sub_q, sub_d;
  logic [W*K-1:0] opA_q, opA_d;
  logic [W*K-1:0] opB_q, opB_d;
  logic [W*K-1:0] result_q, result_d;
  logic           cout_q, cout_d;
  logic           ovf_q, ovf_d;

  logic [W-1:0]   sliceA, sliceB, sliceSum;
  logic           sliceCout;
  logic           lastSlice;
  logic [W*K-1:0] reqA;

`ifdef WIDE_ADD_SEQ_ACC_EN
  logic [W*K-1:0] acc_q;

  // The accumulator tracks the last result actually delivered to the consumer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (out_valid && out_ready) begin
      acc_q <= result_q;
    end
  end

  assign reqA = in_acc ? acc_q : in_a;
`else
  assign reqA = in_a;
`endif

  assign sliceA    = opA_q[idx_q*W +: W];
  assign sliceB    = opB_q[idx_q*W +: W] ^ {W{sub_q}};
  assign lastSlice = (idx_q == IW'(K - 1));

  rca_16b u_slice (
    .a_i    (sliceA),
    .b_i    (sliceB),
    .cin_i  (carry_q),
    .sum_o  (sliceSum),
    .cout_o (sliceCout)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    sub_d     = sub_q;
    opA_d     = opA_q;
    opB_d     = opB_q;
    result_d  = result_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          opA_d   = reqA;
          opB_d   = in_b;
          sub_d   = in_sub;
          carry_d = in_sub;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        result_d[idx_q*W +: W] = sliceSum;
        carry_d = sliceCout;
        if (lastSlice) begin
          cout_d  = sliceCout;
          // Signed overflow compares operand signs after B has been conditionally inverted.
          ovf_d   = (opA_q[W*K-1] == (opB_q[W*K-1] ^ sub_q)) &&
                    (sliceSum[W-1] != opA_q[W*K-1]);
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      sub_q    <= 1'b0;
      opA_q    <= '0;
      opB_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      sub_q    <= sub_d;
      opA_q    <= opA_d;
      opB_q    <= opB_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign out_sum  = result_q;
  assign out_cout = cout_q;
  assign out_ovf  = ovf_q;

endmodule
